// File: rtl/bus_lsu_master.sv
// Single-outstanding load/store master: CPU byte-addressed requests in, one pipelined
// wishbone transfer out, aligned/extended response back with an error cause.
package bus;
  typedef struct packed {
    logic        cyc;
    logic        stb;
    logic        we;
    logic [3:0]  sel;
    logic [29:0] addr;
    logic [31:0] data;
  } m2s_s;

  typedef struct packed {
    logic        ack;
    logic        err;
    logic        stall;
    logic [31:0] data;
  } s2m_s;
endpackage

module bus_lsu_master #(
  parameter int TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [1:0]  req_size,
  input  logic        req_signed,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic [1:0]  rsp_cause,
  output bus::m2s_s   bus_o,
  input  bus::s2m_s   bus_i
);
  localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

  typedef enum logic [1:0] {IDLE, REQ, WAIT, RESP} state_e;

  state_e      state_q;
  logic [CW-1:0] cnt_q;
  bus::m2s_s   bus_q;
  logic        ready_q;
  logic        rsp_valid_q;
  logic        rsp_err_q;
  logic [31:0] rsp_rdata_q;
  logic [1:0]  rsp_cause_q;
  logic [1:0]  off_q;
  logic [1:0]  size_q;
  logic        signed_q;

  logic        accept;
  logic        misaligned_d;
  logic        active;
  logic        fin_bus;
  logic        tmo;
  logic [3:0]  sel_d;
  logic [31:0] wdata_d;
  logic [31:0] shifted;
  logic [31:0] rdata_d;

  always_comb begin
    accept       = req_valid & ready_q;
    misaligned_d = (req_size == 2'b11)
                 | ((req_size == 2'b01) & req_addr[0])
                 | ((req_size == 2'b10) & (|req_addr[1:0]));
    sel_d   = 4'b1111;
    wdata_d = req_wdata;
    case (req_size)
      2'b00: begin
        sel_d   = 4'b0001 << req_addr[1:0];
        wdata_d = {4{req_wdata[7:0]}};
      end
      2'b01: begin
        sel_d   = req_addr[1] ? 4'b1100 : 4'b0011;
        wdata_d = {2{req_wdata[15:0]}};
      end
      default: ;
    endcase

    shifted = bus_i.data >> {off_q, 3'b000};
    rdata_d = shifted;
    case (size_q)
      2'b00:   rdata_d = {{24{signed_q & shifted[7]}}, shifted[7:0]};
      2'b01:   rdata_d = {{16{signed_q & shifted[15]}}, shifted[15:0]};
      default: ;
    endcase

    active  = (state_q == REQ) || (state_q == WAIT);
    // In REQ a response only counts once the strobe has actually been taken
    fin_bus = (bus_i.ack | bus_i.err)
            & ((state_q == WAIT) | ((state_q == REQ) & ~bus_i.stall));
    tmo     = active && (TIMEOUT != 0) && (cnt_q == CW'(TIMEOUT - 1));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      bus_q       <= '0;
      ready_q     <= 1'b1;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_cause_q <= 2'b00;
      off_q       <= 2'b00;
      size_q      <= 2'b00;
      signed_q    <= 1'b0;
    end else begin
      rsp_valid_q <= 1'b0;
      case (state_q)
        // RESP always falls back to IDLE, so it takes a new request too (3-cycle issue)
        IDLE, RESP: begin
          state_q <= IDLE;
          ready_q <= 1'b1;
          if (accept) begin
            cnt_q    <= '0;
            off_q    <= req_addr[1:0];
            size_q   <= req_size;
            signed_q <= req_signed;
            if (misaligned_d) begin
              state_q     <= RESP;
              rsp_valid_q <= 1'b1;
              rsp_err_q   <= 1'b1;
              rsp_cause_q <= 2'b10;
              rsp_rdata_q <= '0;
            end else begin
              state_q    <= REQ;
              ready_q    <= 1'b0;
              bus_q.cyc  <= 1'b1;
              bus_q.stb  <= 1'b1;
              bus_q.we   <= req_we;
              bus_q.sel  <= sel_d;
              bus_q.addr <= req_addr[31:2];
              bus_q.data <= wdata_d;
            end
          end
        end
        default: begin
          if (fin_bus) begin
            state_q     <= RESP;
            ready_q     <= 1'b1;
            bus_q.cyc   <= 1'b0;
            bus_q.stb   <= 1'b0;
            rsp_valid_q <= 1'b1;
            rsp_err_q   <= bus_i.err;
            rsp_cause_q <= bus_i.err ? 2'b01 : 2'b00;
            rsp_rdata_q <= (bus_i.err | bus_q.we) ? 32'h0 : rdata_d;
          end else if (tmo) begin
            state_q     <= RESP;
            ready_q     <= 1'b1;
            bus_q.cyc   <= 1'b0;
            bus_q.stb   <= 1'b0;
            rsp_valid_q <= 1'b1;
            rsp_err_q   <= 1'b1;
            rsp_cause_q <= 2'b11;
            rsp_rdata_q <= '0;
          end else begin
            cnt_q <= cnt_q + 1'b1;
            if ((state_q == REQ) && !bus_i.stall) begin
              bus_q.stb <= 1'b0;
              state_q   <= WAIT;
            end
          end
        end
      endcase
    end
  end

  assign req_ready = ready_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_err   = rsp_err_q;
  assign rsp_cause = rsp_cause_q;
  assign bus_o     = bus_q;
endmodule

// File: tb/tb_bus_lsu_master.sv
// Bench for bus_lsu_master: directed and random requests against a byte-level memory
// model, with a scripted wishbone slave (stall count, ack/err/both/silent).
module tb_bus_lsu_master;
  localparam int TMO = 8;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_we = 1'b0;
  logic [31:0] req_addr = '0;
  logic [1:0]  req_size = '0;
  logic        req_signed = 1'b0;
  logic [31:0] req_wdata = '0;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic [1:0]  rsp_cause;
  bus::m2s_s   m2s;
  bus::s2m_s   s2m = '0;

  int total = 0;
  int bad = 0;

  // slave script
  int   stall_left = 0;
  int   mode = 0;
  bit   armed = 0;
  bit   inject_late = 0;
  logic op_we;
  logic [3:0]  op_sel;
  logic [29:0] op_addr;
  logic [31:0] op_data;
  logic [31:0] smem [bit [29:0]];

  // bus monitor
  int   cyc_seen, stb_seen, rsp_pulses;
  bit   got_stb, stable_bad;
  logic [3:0]  m_sel;
  logic [29:0] m_addr;
  logic        m_we;
  logic [31:0] m_data;

  // reference byte memory
  logic [7:0] rmem [bit [31:0]];

  bus_lsu_master #(.TIMEOUT(TMO)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_size(req_size), .req_signed(req_signed),
    .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .rsp_cause(rsp_cause), .bus_o(m2s), .bus_i(s2m)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] sread(input logic [29:0] a);
    return smem.exists(a) ? smem[a] : 32'h0;
  endfunction

  function automatic logic [7:0] rbyte(input logic [31:0] a);
    return rmem.exists(a) ? rmem[a] : 8'h0;
  endfunction

  // One clock: observe the bus for this cycle, then drive the slave's answer to it.
  task automatic tick();
    logic [31:0] w;
    @(posedge clk);
    #1;
    if (m2s.cyc) cyc_seen++;
    if (m2s.stb) begin
      stb_seen++;
      if (!got_stb) begin
        got_stb = 1; m_sel = m2s.sel; m_addr = m2s.addr; m_we = m2s.we; m_data = m2s.data;
      end
    end
    if (m2s.cyc && got_stb &&
        (m2s.sel !== m_sel || m2s.addr !== m_addr || m2s.we !== m_we || m2s.data !== m_data))
      stable_bad = 1;
    if (rsp_valid) rsp_pulses++;
    s2m.ack = 0; s2m.err = 0; s2m.stall = 0; s2m.data = $urandom;
    if (armed) begin
      armed = 0;
      case (mode)
        0: begin
          s2m.ack = 1;
          if (op_we) begin
            w = sread(op_addr);
            for (int i = 0; i < 4; i++) if (op_sel[i]) w[8*i +: 8] = op_data[8*i +: 8];
            smem[op_addr] = w;
          end else s2m.data = sread(op_addr);
        end
        1: s2m.err = 1;
        2: begin s2m.ack = 1; s2m.err = 1; end
        default: ;
      endcase
    end else if (m2s.cyc && m2s.stb) begin
      if (stall_left > 0) begin
        s2m.stall = 1; stall_left--;
      end else begin
        armed = 1; op_we = m2s.we; op_sel = m2s.sel; op_addr = m2s.addr; op_data = m2s.data;
      end
    end
    if (inject_late) begin s2m.ack = 1; inject_late = 0; end
  endtask

  // md: 0 ack, 1 err, 2 ack+err, 3 silent
  task automatic do_req(input logic we, input logic [31:0] addr, input logic [1:0] size,
                        input logic sgn, input logic [31:0] wdata, input int stalls, input int md);
    int nb, lat, exp_lat;
    bit mis;
    logic [1:0]  exp_cause;
    logic [31:0] exp_rdata, exp_wd;
    logic [7:0]  mask;
    nb  = (size == 2'd0) ? 1 : (size == 2'd1) ? 2 : 4;
    mis = (size == 2'd3) || ((addr % nb) != 0);
    exp_lat   = mis ? 1 : (md == 3) ? TMO + 1 : 3 + stalls;
    exp_cause = mis ? 2'd2 : (md == 3) ? 2'd3 : (md == 0) ? 2'd0 : 2'd1;
    exp_rdata = 0;
    if (!mis && md == 0) begin
      if (we) begin
        for (int i = 0; i < nb; i++) rmem[addr + i] = wdata[8*i +: 8];
      end else begin
        for (int i = 0; i < nb; i++) exp_rdata = exp_rdata | (32'(rbyte(addr + i)) << (8*i));
        if (sgn && nb < 4 && exp_rdata[8*nb-1]) exp_rdata = exp_rdata | ~((32'd1 << (8*nb)) - 1);
      end
    end
    mask   = 8'(((1 << nb) - 1) << addr[1:0]);
    exp_wd = (nb == 1) ? {4{wdata[7:0]}} : (nb == 2) ? {2{wdata[15:0]}} : wdata;

    mode = md; stall_left = stalls; armed = 0;
    cyc_seen = 0; stb_seen = 0; got_stb = 0; stable_bad = 0; rsp_pulses = 0;
    check("ready_before", 32'(req_ready), 32'd1);
    req_valid = 1; req_we = we; req_addr = addr; req_size = size; req_signed = sgn; req_wdata = wdata;
    tick();
    req_valid = 0; req_we = 1'($urandom); req_addr = $urandom; req_size = 2'($urandom);
    req_signed = 1'($urandom); req_wdata = $urandom;
    lat = 1;
    while (!rsp_valid && lat < 40) begin tick(); lat++; end
    check("latency", 32'(lat), 32'(exp_lat));
    check("cause", 32'(rsp_cause), 32'(exp_cause));
    check("err", 32'(rsp_err), 32'(exp_cause != 2'd0));
    check("rdata", rsp_rdata, exp_rdata);
    check("ready_at_rsp", 32'(req_ready), 32'd1);
    check("cyc_cycles", 32'(cyc_seen), mis ? 32'd0 : (md == 3) ? 32'(TMO) : 32'(stalls + 2));
    check("stb_cycles", 32'(stb_seen), mis ? 32'd0 : 32'(stalls + 1));
    if (!mis) begin
      check("sel", 32'(m_sel), 32'(mask[3:0]));
      check("addr", 32'(m_addr), 32'(addr[31:2]));
      check("we", 32'(m_we), 32'(we));
      if (we) check("wdata", m_data, exp_wd);
      check("stable", 32'(stable_bad), 32'd0);
    end
    tick();
    check("rsp_pulse", 32'(rsp_valid), 32'd0);
    check("rdata_hold", rsp_rdata, exp_rdata);
  endtask

  logic [31:0] byte_u [4];
  logic [31:0] byte_s [4];

  initial begin
    byte_u = '{32'h01, 32'h7F, 32'hFF, 32'h80};
    byte_s = '{32'h01, 32'h7F, 32'hFFFFFFFF, 32'hFFFFFF80};

    tick(); tick();
    check("rst_ready", 32'(req_ready), 32'd1);
    check("rst_valid", 32'(rsp_valid), 32'd0);
    check("rst_err", 32'(rsp_err), 32'd0);
    check("rst_cause", 32'(rsp_cause), 32'd0);
    check("rst_rdata", rsp_rdata, 32'd0);
    check("rst_bus", 32'(m2s === '0), 32'd1);
    rst = 0;
    tick();

    do_req(1, 32'h100, 2'd2, 0, 32'hDEADBEEF, 0, 0);
    check("word_store_sel", 32'(m_sel), 32'hF);
    check("word_store_addr", 32'(m_addr), 32'h40);
    do_req(0, 32'h100, 2'd2, 0, 32'h0, 0, 0);
    check("word_load", rsp_rdata, 32'hDEADBEEF);

    do_req(1, 32'h200, 2'd2, 0, 32'h80FF7F01, 0, 0);
    for (int k = 0; k < 4; k++) begin
      do_req(0, 32'h200 + k, 2'd0, 0, 32'h0, 0, 0);
      check("byte_u", rsp_rdata, byte_u[k]);
      do_req(0, 32'h200 + k, 2'd0, 1, 32'h0, 0, 0);
      check("byte_s", rsp_rdata, byte_s[k]);
    end
    for (int k = 0; k < 4; k++) begin
      do_req(1, 32'h300 + k, 2'd0, 0, 32'($urandom), 0, 0);
      check("byte_store_sel", 32'(m_sel), 32'(4'b0001 << k));
    end

    do_req(0, 32'h103, 2'd1, 0, 32'h0, 0, 0);
    do_req(1, 32'h102, 2'd2, 0, 32'h12345678, 0, 0);
    do_req(0, 32'h100, 2'd3, 0, 32'h0, 0, 0);

    do_req(0, 32'h100, 2'd2, 0, 32'h0, 4, 1);
    check("stall_stb_5", 32'(stb_seen), 32'd5);
    do_req(0, 32'h104, 2'd2, 0, 32'h0, 0, 2);
    check("ack_err_cause", 32'(rsp_cause), 32'd1);

    do_req(0, 32'h108, 2'd2, 0, 32'h0, 0, 3);
    inject_late = 1; rsp_pulses = 0; cyc_seen = 0;
    repeat (5) tick();
    check("late_ack_pulses", 32'(rsp_pulses), 32'd0);
    check("late_ack_cyc", 32'(cyc_seen), 32'd0);

    for (int n = 0; n < 60; n++) begin
      logic [1:0] sz;
      sz = ($urandom_range(0, 9) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
      do_req(1'($urandom), 32'h400 + 32'($urandom_range(0, 15)), sz, 1'($urandom), $urandom,
             int'($urandom_range(0, 3)), ($urandom_range(0, 7) == 0) ? 1 : 0);
    end

    mode = 3; stall_left = 0; armed = 0;
    req_valid = 1; req_we = 0; req_addr = 32'h100; req_size = 2'd2; req_signed = 0;
    tick();
    req_valid = 0;
    tick();
    check("wait_cyc_before_rst", 32'(m2s.cyc), 32'd1);
    #2 rst = 1;
    #1;
    check("rst_async_cyc", 32'(m2s.cyc), 32'd0);
    check("rst_async_stb", 32'(m2s.stb), 32'd0);
    rsp_pulses = 0;
    tick(); tick();
    rst = 0; armed = 0;
    tick(); tick(); tick();
    check("rst_no_rsp", 32'(rsp_pulses), 32'd0);
    do_req(0, 32'h100, 2'd2, 0, 32'h0, 0, 0);
    check("after_rst_load", rsp_rdata, 32'hDEADBEEF);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
